// File: rtl/dpram_readout_pkg.sv
// ---------------------------------------------------------------------------
// dpram_readout_pkg
// Shared definitions for the DPRAM readout block: FSM state encoding,
// the default DPRAM depth and the DPRAM port B read latency.
//
// Optional feature macro: DPRAM_RDOUT_CKSUM_EN (enables the CKSUM state).
// ---------------------------------------------------------------------------
package dpram_readout_pkg;

  // Default DPRAM depth in 32-bit words (2^10).
  localparam int DPRAM_DEPTH = 1024;

  // Port B returns data this many cycles after the address is presented.
  // The single LAT state in the FSM covers exactly this latency.
  localparam int DPRAM_RD_LATENCY = 1;

  // ST_CKSUM is only reachable when DPRAM_RDOUT_CKSUM_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_LAT   = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4,
    ST_CKSUM = 3'd5
  } state_t;

endpackage

// File: rtl/dpram_rdout_cksum.sv
// ---------------------------------------------------------------------------
// dpram_rdout_cksum
// 32-bit wrap-around sum of the data words of one transfer.
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   clear in   zero the sum (start of a transfer)
//   add   in   accumulate data this cycle
//   data  in   [31:0] word to accumulate
//   sum   out  [31:0] running sum
//
// Only instantiated when DPRAM_RDOUT_CKSUM_EN is defined.
// ---------------------------------------------------------------------------
module dpram_rdout_cksum
  import dpram_readout_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        add,
  input  logic [31:0] data,
  output logic [31:0] sum
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + data;
    end
  end

endmodule

// File: rtl/dpram_readout.sv
// ---------------------------------------------------------------------------
// dpram_readout
// Consumer side of the waveform-reader DPRAM handoff. On dpram_run it takes
// ownership of the DPRAM (dpram_busy), reads dpram_len words in address
// order through port B, streams them out on a valid/ready word interface
// and pulses dpram_done to hand the DPRAM back to the reader.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   dpram_run     in   one-cycle start pulse (ignored while busy)
//   dpram_len     in   [P_LEN_WIDTH-1:0] word count, sampled with dpram_run
//   dpram_busy    out  high in every state except IDLE
//   dpram_done    out  one-cycle pulse at the end of a transfer
//   rd_addr       out  [P_ADR_WIDTH-1:0] port B read address
//   rd_data       in   [31:0] port B data, valid one cycle after rd_addr
//   out_data      out  [31:0] streamed word
//   out_valid     out  word valid
//   out_ready     in   sink ready
//   out_last      out  final word of the transfer
//   xfer_cnt      out  [P_LEN_WIDTH-1:0] completed transfers, wraps
//   len_err       out  sticky: a dpram_len above the DPRAM depth was seen
//
// Handshake: a word transfers on every rising clk edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_data/out_last stay
// constant and out_valid stays high until that transfer happens; out_valid
// never depends combinationally on out_ready.
//
// Optional feature macro: DPRAM_RDOUT_CKSUM_EN -- appends one word holding
// the 32-bit wrap-around sum of the data words; out_last moves onto it.
// ---------------------------------------------------------------------------
module dpram_readout
  import dpram_readout_pkg::*;
#(
  parameter int P_ADR_WIDTH = 10,
  parameter int P_LEN_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dpram_run,
  input  logic [P_LEN_WIDTH-1:0] dpram_len,
  output logic                   dpram_busy,
  output logic                   dpram_done,
  output logic [P_ADR_WIDTH-1:0] rd_addr,
  input  logic [31:0]            rd_data,
  output logic [31:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [P_LEN_WIDTH-1:0] xfer_cnt,
  output logic                   len_err
);

  localparam int DEPTH = 1 << P_ADR_WIDTH;
  // One extra bit so a full-depth transfer count fits.
  localparam int CNT_W = P_ADR_WIDTH + 1;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             len_too_long;
  logic             last_data_word;

  assign len_too_long   = 32'(dpram_len) > 32'(DEPTH);
  assign last_data_word = (remaining == CNT_W'(1));

`ifdef DPRAM_RDOUT_CKSUM_EN
  logic        cksum_clear;
  logic        cksum_add;
  logic [31:0] cksum_sum;

  // Words are summed as they are captured in LAT, so the sum already
  // includes the final data word by the time its handshake happens.
  assign cksum_clear = (state == ST_IDLE) && dpram_run;
  assign cksum_add   = (state == ST_LAT);

  dpram_rdout_cksum u_cksum (
    .clk   (clk),
    .rst   (rst),
    .clear (cksum_clear),
    .add   (cksum_add),
    .data  (rd_data),
    .sum   (cksum_sum)
  );
`endif

  // rd_addr doubles as the word address register: it holds the address of
  // the word in flight from RD through SEND and only advances on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      dpram_busy <= 1'b0;
      dpram_done <= 1'b0;
      rd_addr    <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      xfer_cnt   <= '0;
      len_err    <= 1'b0;
    end else begin
      dpram_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dpram_run) begin
            dpram_busy <= 1'b1;
            rd_addr    <= '0;
            if (dpram_len == '0) begin
              remaining  <= '0;
              dpram_done <= 1'b1;
              xfer_cnt   <= xfer_cnt + 1'b1;
              state      <= ST_DONE;
            end else if (len_too_long) begin
              remaining <= CNT_W'(DEPTH);
              len_err   <= 1'b1;
              state     <= ST_RD;
            end else begin
              remaining <= CNT_W'(dpram_len);
              state     <= ST_RD;
            end
          end
        end

        ST_RD: begin
          state <= ST_LAT;
        end

        ST_LAT: begin
          out_data  <= rd_data;
          out_valid <= 1'b1;
`ifdef DPRAM_RDOUT_CKSUM_EN
          out_last  <= 1'b0;
`else
          out_last  <= last_data_word;
`endif
          state     <= ST_SEND;
        end

        ST_SEND: begin
          if (out_ready) begin
            if (last_data_word) begin
`ifdef DPRAM_RDOUT_CKSUM_EN
              out_data   <= cksum_sum;
              out_valid  <= 1'b1;
              out_last   <= 1'b1;
              state      <= ST_CKSUM;
`else
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              dpram_done <= 1'b1;
              xfer_cnt   <= xfer_cnt + 1'b1;
              state      <= ST_DONE;
`endif
            end else begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              rd_addr   <= rd_addr + 1'b1;
              remaining <= remaining - 1'b1;
              state     <= ST_RD;
            end
          end
        end

`ifdef DPRAM_RDOUT_CKSUM_EN
        ST_CKSUM: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            dpram_done <= 1'b1;
            xfer_cnt   <= xfer_cnt + 1'b1;
            state      <= ST_DONE;
          end
        end
`endif

        ST_DONE: begin
          dpram_busy <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          dpram_busy <= 1'b0;
          out_valid  <= 1'b0;
          out_last   <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_readout.sv
// ---------------------------------------------------------------------------
// tb_dpram_readout
// Testbench for dpram_readout: behavioural DPRAM, randomized contents and
// sink backpressure, expected words built from the DPRAM contents and the
// transfer length.
// ---------------------------------------------------------------------------
module tb_dpram_readout;
  import dpram_readout_pkg::*;

  logic        clk;
  logic        rst;
  logic        dpram_run;
  logic [15:0] dpram_len;
  logic        dpram_busy;
  logic        dpram_done;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] xfer_cnt;
  logic        len_err;

  dpram_readout #(.P_ADR_WIDTH(10), .P_LEN_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .dpram_run  (dpram_run),
    .dpram_len  (dpram_len),
    .dpram_busy (dpram_busy),
    .dpram_done (dpram_done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .xfer_cnt   (xfer_cnt),
    .len_err    (len_err)
  );

  // ---------------- clock / DPRAM model ----------------
  always #5 clk = ~clk;

  logic [31:0] mem [DPRAM_DEPTH];
  always @(posedge clk) rd_data <= mem[rd_addr];

  // ---------------- scoreboard state ----------------
  int checks;
  int errors;
  int exp_xfer;
  int exp_n;
  int exp_done;
  logic [31:0] exp_q[$];

  logic [31:0] got_data[$];
  bit          got_last[$];
  logic [9:0]  got_addr[$];
  int done_cyc, done_cnt, busy_fall, first_valid, unstable, timed_out;
  logic busy_at1;
  logic [9:0] addr_at1;

  // ---------------- helpers ----------------
  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return ((k / 2) % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic fill_mem(input bit pattern);
    for (int i = 0; i < DPRAM_DEPTH; i++)
      mem[i] = pattern ? (32'hA000_0000 + 32'(i)) : $urandom;
  endtask

  // Reference: the first min(len, depth) words in address order, plus the
  // wrap-around sum when the checksum feature is built in.
  task automatic build_exp(input int len);
    logic [31:0] sum;
    sum = '0;
    exp_q.delete();
    exp_n = (len > DPRAM_DEPTH) ? DPRAM_DEPTH : len;
    for (int i = 0; i < exp_n; i++) begin
      exp_q.push_back(mem[i]);
      sum = sum + mem[i];
    end
    exp_done = (exp_n == 0) ? 1 : 3 * exp_n + 1;
`ifdef DPRAM_RDOUT_CKSUM_EN
    if (exp_n > 0) begin
      exp_q.push_back(sum);
      exp_done = exp_done + 1;
    end
`endif
  endtask

  // Driver + monitor for one transfer. Cycle 0 is the cycle dpram_run is
  // high; observations are taken at the falling edge of each cycle.
  task automatic do_xfer(input int len, input int rmode, input int repulse_at);
    int k;
    int budget;
    int stop_at;
    bit prev_stall;
    logic [31:0] prev_data;
    got_data.delete(); got_last.delete(); got_addr.delete();
    done_cyc = -1; done_cnt = 0; busy_fall = -1; first_valid = -1;
    unstable = 0; timed_out = 0; busy_at1 = 1'b0; addr_at1 = '1;
    budget = 20 * ((len > DPRAM_DEPTH) ? DPRAM_DEPTH : len) + 60;
    stop_at = -1;
    @(negedge clk);
    dpram_len = 16'(len);
    dpram_run = 1'b1;
    out_ready = ready_for(rmode, 0);
    k = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    while (1) begin
      @(negedge clk);
      k++;
      dpram_run = (k == repulse_at);
      if (k == repulse_at) dpram_len = 16'd7;
      out_ready = ready_for(rmode, k);
      if (k == 1) begin
        busy_at1 = dpram_busy;
        addr_at1 = rd_addr;
      end
      if (out_valid && first_valid < 0) first_valid = k;
      if (prev_stall && (!out_valid || out_data !== prev_data)) unstable++;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        got_addr.push_back(rd_addr);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (dpram_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (done_cyc >= 0 && !dpram_busy && busy_fall < 0) begin
        busy_fall = k;
        stop_at = k + 5;
      end
      if (k == stop_at) break;
      if (k > budget) begin
        timed_out = 1;
        break;
      end
    end
    dpram_run = 1'b0;
    out_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (dpram_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", dpram_busy); end
    checks++; if (dpram_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", dpram_done); end
    checks++; if (rd_addr !== 10'd0) begin errors++; $display("FAIL rst_rd_addr got %0d exp 0", rd_addr); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b exp 0", out_last); end
    checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL rst_xfer_cnt got %0d exp 0", xfer_cnt); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL rst_len_err got %b exp 0", len_err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    fill_mem(1'b1);
    build_exp(3);
    do_xfer(3, 0, -1);
    exp_xfer++;
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got 1 exp 0"); end
    checks++; if (busy_at1 !== 1'b1) begin errors++; $display("FAIL basic_busy_c1 got %b exp 1", busy_at1); end
    checks++; if (addr_at1 !== 10'd0) begin errors++; $display("FAIL basic_addr_c1 got %0d exp 0", addr_at1); end
    checks++; if (first_valid != 3) begin errors++; $display("FAIL basic_first_valid got %0d exp 3", first_valid); end
    checks++; if (done_cyc != exp_done) begin errors++; $display("FAIL basic_done_cyc got %0d exp %0d", done_cyc, exp_done); end
    checks++; if (busy_fall != exp_done + 1) begin errors++; $display("FAIL basic_busy_fall got %0d exp %0d", busy_fall, exp_done + 1); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (xfer_cnt !== 16'(exp_xfer)) begin errors++; $display("FAIL basic_xfer_cnt got %0d exp %0d", xfer_cnt, exp_xfer); end
    checks++; if (got_data.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got %0d exp %0d", got_data.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
        errors++; $display("FAIL basic_word%0d got %h/%b exp %h/%b", i, got_data[i], got_last[i], exp_q[i], i == exp_q.size() - 1);
      end
    end
  endtask

  task automatic test_backpressure;
    fill_mem(1'b0);
    build_exp(4);
    do_xfer(4, 1, -1);
    exp_xfer++;
    checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout got 1 exp 0"); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", unstable); end
    checks++; if (got_data.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d exp %0d", got_data.size(), exp_q.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_cnt got %0d exp 1", done_cnt); end
    for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
        errors++; $display("FAIL bp_word%0d got %h/%b exp %h", i, got_data[i], got_last[i], exp_q[i]);
      end
      if (i < exp_n) begin
        checks++;
        if (got_addr[i] !== 10'(i)) begin errors++; $display("FAIL bp_addr%0d got %0d exp %0d", i, got_addr[i], i); end
      end
    end
  endtask

  task automatic test_len_zero;
    build_exp(0);
    do_xfer(0, 0, -1);
    exp_xfer++;
    checks++; if (timed_out) begin errors++; $display("FAIL zero_timeout got 1 exp 0"); end
    checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cyc got %0d exp 1", done_cyc); end
    checks++; if (busy_fall != 2) begin errors++; $display("FAIL zero_busy_fall got %0d exp 2", busy_fall); end
    checks++; if (first_valid != -1) begin errors++; $display("FAIL zero_valid got cycle %0d exp none", first_valid); end
    checks++; if (xfer_cnt !== 16'(exp_xfer)) begin errors++; $display("FAIL zero_xfer_cnt got %0d exp %0d", xfer_cnt, exp_xfer); end
  endtask

  task automatic test_repulse;
    fill_mem(1'b0);
    build_exp(5);
    do_xfer(5, 0, 4);
    exp_xfer++;
    checks++; if (timed_out) begin errors++; $display("FAIL repulse_timeout got 1 exp 0"); end
    checks++; if (got_data.size() != exp_q.size()) begin errors++; $display("FAIL repulse_count got %0d exp %0d", got_data.size(), exp_q.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL repulse_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (done_cyc != exp_done) begin errors++; $display("FAIL repulse_done_cyc got %0d exp %0d", done_cyc, exp_done); end
    for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_q[i]) begin errors++; $display("FAIL repulse_word%0d got %h exp %h", i, got_data[i], exp_q[i]); end
    end
  endtask

  task automatic test_random;
    int len;
    for (int t = 0; t < 4; t++) begin
      fill_mem(1'b0);
      len = $urandom_range(1, 40);
      build_exp(len);
      do_xfer(len, 2, -1);
      exp_xfer++;
      checks++; if (timed_out) begin errors++; $display("FAIL rand%0d_timeout got 1 exp 0", t); end
      checks++; if (unstable != 0) begin errors++; $display("FAIL rand%0d_stable got %0d exp 0", t, unstable); end
      checks++; if (got_data.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", t, got_data.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
        checks++;
        if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
          errors++; $display("FAIL rand%0d_word%0d got %h/%b exp %h", t, i, got_data[i], got_last[i], exp_q[i]);
        end
      end
    end
    checks++; if (xfer_cnt !== 16'(exp_xfer)) begin errors++; $display("FAIL rand_xfer_cnt got %0d exp %0d", xfer_cnt, exp_xfer); end
  endtask

  task automatic test_len_err;
    int bad;
    bad = 0;
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL lenerr_pre got %b exp 0", len_err); end
    fill_mem(1'b0);
    build_exp(1035);
    do_xfer(1035, 0, -1);
    exp_xfer++;
    checks++; if (timed_out) begin errors++; $display("FAIL lenerr_timeout got 1 exp 0"); end
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL lenerr_flag got %b exp 1", len_err); end
    checks++; if (got_data.size() != exp_q.size()) begin errors++; $display("FAIL lenerr_count got %0d exp %0d", got_data.size(), exp_q.size()); end
    checks++;
    if (got_addr.size() < 1024 || got_addr[1023] !== 10'd1023) begin
      errors++; $display("FAIL lenerr_last_addr got %0d exp 1023", (got_addr.size() >= 1024) ? int'(got_addr[1023]) : -1);
    end
    for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
      if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) bad++;
      if (i < exp_n && got_addr[i] !== 10'(i)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL lenerr_words got %0d bad exp 0", bad); end
    @(negedge clk);
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL lenerr_sticky got %b exp 1", len_err); end
  endtask

  task automatic test_reset_mid;
    int hs;
    int k;
    int saw_done;
    hs = 0; k = 0; saw_done = 0;
    fill_mem(1'b0);
    @(negedge clk);
    dpram_len = 16'd6; dpram_run = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    dpram_run = 1'b0;
    while (hs < 2 && k < 100) begin
      if (out_valid && out_ready) hs++;
      if (dpram_done) saw_done++;
      @(negedge clk);
      k++;
    end
    checks++; if (k >= 100) begin errors++; $display("FAIL rstmid_timeout got %0d handshakes exp 2", hs); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dpram_busy, dpram_done, rd_addr, out_data, out_valid, out_last, xfer_cnt, len_err} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got busy %b done %b addr %0d data %h valid %b last %b cnt %0d err %b exp all 0",
               dpram_busy, dpram_done, rd_addr, out_data, out_valid, out_last, xfer_cnt, len_err);
    end
    repeat (2) begin
      @(negedge clk);
      if (dpram_done) saw_done++;
    end
    rst = 1'b0;
    exp_xfer = 0;
    repeat (4) begin
      @(negedge clk);
      if (dpram_done) saw_done++;
    end
    checks++; if (saw_done != 0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", saw_done); end
    build_exp(2);
    do_xfer(2, 0, -1);
    exp_xfer++;
    checks++; if (timed_out) begin errors++; $display("FAIL rstmid_timeout2 got 1 exp 0"); end
    checks++; if (done_cyc != exp_done) begin errors++; $display("FAIL rstmid_done_cyc got %0d exp %0d", done_cyc, exp_done); end
    checks++; if (xfer_cnt !== 16'(exp_xfer)) begin errors++; $display("FAIL rstmid_xfer_cnt got %0d exp %0d", xfer_cnt, exp_xfer); end
    checks++; if (got_data.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count got %0d exp %0d", got_data.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_q[i] || got_last[i] !== (i == exp_q.size() - 1)) begin
        errors++; $display("FAIL rstmid_word%0d got %h/%b exp %h", i, got_data[i], got_last[i], exp_q[i]);
      end
    end
  endtask

`ifdef DPRAM_RDOUT_CKSUM_EN
  task automatic test_cksum;
    mem[0] = 32'hFFFF_FFFF;
    mem[1] = 32'h0000_0002;
    build_exp(2);
    do_xfer(2, 0, -1);
    exp_xfer++;
    checks++; if (got_data.size() != 3) begin errors++; $display("FAIL cksum_count got %0d exp 3", got_data.size()); end
    checks++;
    if (got_data.size() < 3 || got_data[2] !== 32'h0000_0001 || got_last[2] !== 1'b1 || got_last[1] !== 1'b0) begin
      errors++; $display("FAIL cksum_word got %h exp 00000001 with last", (got_data.size() >= 3) ? got_data[2] : 32'hx);
    end
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    clk = 1'b0;
    rst = 1'b0;
    dpram_run = 1'b0;
    dpram_len = '0;
    out_ready = 1'b1;
    checks = 0;
    errors = 0;
    exp_xfer = 0;
    fill_mem(1'b1);
    #1 rst = 1'b1;
    test_reset;
    test_basic;
    test_backpressure;
    test_len_zero;
    test_repulse;
    test_random;
    test_len_err;
    test_reset_mid;
`ifdef DPRAM_RDOUT_CKSUM_EN
    test_cksum;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
